// File: rtl/dec38_pkg.sv
// Shared types and constants for the 3-to-8 request dispatcher.
package dec38_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;

    // Dispatcher sequencing: wait for a request, drive it, then report.
    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE
    } state_t;

    // How the ASSERT phase ended; selects the completion pulse in RELEASE.
    typedef enum logic {
        RES_OK,
        RES_TIMEOUT
    } result_t;

endpackage

// File: rtl/dec38_onehot.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero when disabled.
module dec38_onehot
    import dec38_pkg::*;
(
    input  logic                enable,
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    // Decode the index into a single set bit, or nothing when disabled.
    always_comb begin
        onehot = '0;
        if (enable) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/dec38_dispatch.sv
// Registered 3-to-8 dispatcher: turns an accepted {idc, y} index into a
// one-hot request, holds it for at least HOLD_CYCLES, then completes on the
// target's acknowledge (done) or after TIMEOUT cycles (timeout).
// Optional macro DEC38_ERRCNT_EN: when defined, err_cnt counts timeout
// completions (saturating at 255); otherwise err_cnt is tied to zero.
module dec38_dispatch
    import dec38_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                idc,
    input  logic [CODE_W-1:0]   y,
    output logic                ready,
    output logic [ONEHOT_W-1:0] out_req,
    input  logic [ONEHOT_W-1:0] ack,
    output logic                done,
    output logic                timeout,
    output logic [CODE_W-1:0]   last_code,
    output logic [7:0]          err_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    // One extra bit so counter+1 never wraps before the compare.
    localparam logic [CNT_W:0] HOLD_V    = (CNT_W + 1)'(HOLD_CYCLES);
    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0] ONE_V     = (CNT_W + 1)'(1);

    state_t            state_q, state_d;
    result_t           result_q, result_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_seen_q, ack_seen_d;

    logic [CNT_W:0]    cnt_inc;
    logic              ack_hit;
    logic              hold_met;
    logic              time_up;

    // Cycle count including the current one, and ack including this cycle.
    assign cnt_inc  = {1'b0, cnt_q} + ONE_V;
    assign ack_hit  = ack_seen_q | ack[code_q];
    assign hold_met = (cnt_inc >= HOLD_V);
    assign time_up  = (cnt_inc == TIMEOUT_V);

    // State and datapath registers; reset returns to an idle, silent dispatcher.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= RES_OK;
            code_q      <= '0;
            last_code_q <= '0;
            cnt_q       <= '0;
            ack_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            code_q      <= code_d;
            last_code_q <= last_code_d;
            cnt_q       <= cnt_d;
            ack_seen_q  <= ack_seen_d;
        end
    end

    // Next-state logic: accept in IDLE, time the request in ASSERT, report in RELEASE.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        code_d      = code_q;
        last_code_d = last_code_q;
        cnt_d       = cnt_q;
        ack_seen_d  = ack_seen_q;

        unique case (state_q)
            IDLE: begin
                if (en && idc) begin
                    code_d      = y;
                    last_code_d = y;
                    cnt_d       = '0;
                    ack_seen_d  = 1'b0;
                    state_d     = ASSERT;
                end
            end

            ASSERT: begin
                ack_seen_d = ack_hit;
                if (cnt_inc >= TIMEOUT_V) begin
                    cnt_d = TIMEOUT_V[CNT_W-1:0];
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
                // Success is tested first so an ack on the last cycle beats the timeout.
                if (ack_hit && hold_met) begin
                    result_d = RES_OK;
                    state_d  = RELEASE;
                end else if (time_up) begin
                    result_d = RES_TIMEOUT;
                    state_d  = RELEASE;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The request only exists while in ASSERT, so reset removes it immediately.
    dec38_onehot u_onehot (
        .enable (state_q == ASSERT),
        .code   (code_q),
        .onehot (out_req)
    );

    // Status outputs decoded from the registered state.
    always_comb begin
        ready     = (state_q == IDLE);
        done      = (state_q == RELEASE) && (result_q == RES_OK);
        timeout   = (state_q == RELEASE) && (result_q == RES_TIMEOUT);
        last_code = last_code_q;
    end

`ifdef DEC38_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Count timeout completions, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (timeout && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

`ifndef SYNTHESIS
    a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(done && timeout));
    a_req_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_req));
    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
                                   ready |-> (out_req == '0));
`endif

endmodule

// File: tb/tb_dec38_dispatch.sv
// Scoreboard bench for dec38_dispatch: a driver issues requests and pushes the
// expected completion; a monitor measures each request pulse and checks it.
module tb_dec38_dispatch;

    localparam int HOLD = 4;
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       idc;
    logic [2:0] y;
    logic       ready;
    logic [7:0] out_req;
    logic [7:0] ack;
    logic       done;
    logic       timeout;
    logic [2:0] last_code;
    logic [7:0] err_cnt;

    dec38_dispatch #(
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .idc       (idc),
        .y         (y),
        .ready     (ready),
        .out_req   (out_req),
        .ack       (ack),
        .done      (done),
        .timeout   (timeout),
        .last_code (last_code),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_ok;
        bit [2:0] code;
        int       width;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: ack arriving on ASSERT cycle a (1-based, 0 = never) completes
    // the request at max(a, HOLD) if that is within TMO cycles, else it times out.
    function automatic exp_t model(input bit [2:0] c, input int a);
        exp_t e;
        e.code = c;
        if (a >= 1 && a <= TMO) begin
            e.is_ok = 1'b1;
            e.width = (a > HOLD) ? a : HOLD;
        end else begin
            e.is_ok = 1'b0;
            e.width = TMO;
        end
        return e;
    endfunction

    // Monitor: measure the request pulse and check it at each completion.
    int         run;
    logic [7:0] run_val;
    bit         run_mixed;
    int         exp_err;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run       = 0;
            run_mixed = 1'b0;
            exp_err   = 0;
        end else begin
            if (out_req != 8'h00) begin
                if (run == 0) run_val = out_req;
                else if (out_req !== run_val) run_mixed = 1'b1;
                run++;
            end
            if (done || timeout) begin
                check("pulse_exclusive", {31'b0, done & timeout}, 0);
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_completion: got done=%0b timeout=%0b, expected none",
                             done, timeout);
                end else begin
                    e = sb.pop_front();
                    check("done_flag", {31'b0, done}, {31'b0, e.is_ok});
                    check("timeout_flag", {31'b0, timeout}, {31'b0, !e.is_ok});
                    check("req_width", run, e.width);
                    check("req_onehot", {24'b0, run_val}, {24'b0, 8'(1) << e.code});
                    check("req_stable", {31'b0, run_mixed}, 0);
                    check("last_code", {29'b0, last_code}, {29'b0, e.code});
                    check("err_cnt", {24'b0, err_cnt}, exp_err);
                    check("ready_in_release", {31'b0, ready}, 0);
`ifdef DEC38_ERRCNT_EN
                    if (!e.is_ok && exp_err < 255) exp_err++;
`endif
                end
                run       = 0;
                run_mixed = 1'b0;
            end
        end
    end

    // Driver: idle noise, accept, per-cycle ack/noise during ASSERT. Starts and ends at a negedge.
    task automatic run_txn(input logic [2:0] c, input int a, input int noise, input int mid_y);
        int guard;
        int i;
        repeat (noise) begin
            en  = 1'b0;
            idc = 1'b1;
            y   = 3'($urandom);
            ack = 8'($urandom);
            @(negedge clk);
        end
        guard = 0;
        while (!ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ready: got ready=0, expected 1 within 40 cycles");
            return;
        end
        en  = 1'b1;
        idc = 1'b1;
        y   = c;
        ack = 8'($urandom);
        sb.push_back(model(c, a));
        @(negedge clk);
        check("accept_latency", {24'b0, out_req}, {24'b0, 8'(1) << c});
        i = 1;
        while (out_req != 8'h00 && i <= TMO + 2) begin
            en     = 1'($urandom);
            idc    = (mid_y >= 0) ? 1'b1 : 1'($urandom);
            y      = (mid_y >= 0) ? 3'(mid_y) : 3'($urandom);
            ack    = 8'($urandom) & ~(8'(1) << c);
            ack[c] = (i == a);
            @(negedge clk);
            i++;
        end
        check("release_reached", {24'b0, out_req}, 0);
        ack = 8'h00;
        en  = 1'b0;
        idc = 1'b0;
        @(negedge clk);
        check("ready_after_release", {31'b0, ready}, 1);
    endtask

    // Reset on the second ASSERT cycle; no completion may be reported.
    task automatic reset_mid(input logic [2:0] c);
        en  = 1'b1;
        idc = 1'b1;
        y   = c;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_out_req", {24'b0, out_req}, 0);
        check("rst_done", {30'b0, done, timeout}, 0);
        check("rst_ready", {31'b0, ready}, 1);
        en  = 1'b0;
        idc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("err_cnt_cleared", {24'b0, err_cnt}, 0);
        check("last_code_cleared", {29'b0, last_code}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected bench to end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_final;
        rst = 1'b1;
        en  = 1'b1;
        idc = 1'b1;
        y   = 3'd5;
        ack = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("reset_out_req", {24'b0, out_req}, 0);
        check("reset_ready", {31'b0, ready}, 1);
        check("reset_pulses", {30'b0, done, timeout}, 0);
        check("reset_last_code", {29'b0, last_code}, 0);
        check("reset_err_cnt", {24'b0, err_cnt}, 0);
        rst = 1'b0;

        run_txn(3'd5, 3, 0, -1);        // accepted on the first cycle out of reset
        run_txn(3'd2, 1, 0, -1);        // early ack: exactly HOLD cycles
        run_txn(3'd7, 0, 0, -1);        // no ack: timeout after TMO cycles
        run_txn(3'd0, TMO, 0, -1);      // ack on the timeout cycle: success
        run_txn(3'd3, 6, 0, 6);         // y moves to 6 mid-request, ignored
        run_txn(3'd6, 2, 0, -1);        // next accept takes 6
        run_txn(3'd1, TMO + 1, 1, -1);  // ack just too late

        repeat (60) begin
            run_txn(3'($urandom), int'($urandom_range(0, TMO + 3)),
                    int'($urandom_range(0, 3)), -1);
        end

        reset_mid(3'd4);

        repeat (257) begin
            run_txn(3'($urandom), 0, 0, -1);
        end
`ifdef DEC38_ERRCNT_EN
        exp_final = 255;
`else
        exp_final = 0;
`endif
        check("err_cnt_saturated", {24'b0, err_cnt}, exp_final);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
